// File: rtl/rf_pkg.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Brief    : Shared sizing constants and wordline legality check for the
//             16x16 register file and its write decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    localparam logic [REG_IDX_W-1:0] R0_IDX = 4'd0;

    // A wordline is legal when it has at most one bit set (all-zero means
    // "no write"). Returns 1 for legal, 0 for multi-hot.
    function automatic logic is_onehot16(input logic [15:0] wl);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, wl[i]};
        end
        return (cnt <= 5'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_row.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : rf_row
//  Brief    : One register-file row: a W-bit register with write enable and
//             asynchronous active-high clear.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_row #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Row storage: cleared immediately on reset, loaded when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_16x16.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : reg_file_16x16
//  Brief    : 16-entry register file driven by a one-hot write wordline.
//             Two combinational read ports with write-to-read bypass, R0
//             hardwired to zero, sticky flag for multi-hot wordlines.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_16x16 #(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS-1:0]            Wordline,
    input  logic [DATA_W-1:0]              DstData,
    input  logic [rf_pkg::REG_IDX_W-1:0]   SrcReg1,
    input  logic [rf_pkg::REG_IDX_W-1:0]   SrcReg2,
    output logic [DATA_W-1:0]              SrcData1,
    output logic [DATA_W-1:0]              SrcData2,
    output logic                           WlError
);

    import rf_pkg::*;

    logic                  w_legal;
    logic [DATA_W-1:0]     w_regs [NUM_REGS];
    logic                  r_wl_error;

    // A multi-hot wordline suppresses both the write and the bypass.
    assign w_legal = is_onehot16(Wordline);

    // R0 has no storage.
    assign w_regs[0] = '0;

    generate
        for (genvar k = 1; k < NUM_REGS; k++) begin : g_row
            rf_row #(
                .W    (DATA_W)
            ) u_row (
                .clk  (clk),
                .rst  (rst),
                .i_we (Wordline[k] & w_legal),
                .i_d  (DstData),
                .o_q  (w_regs[k])
            );
        end
    endgenerate

    // Sticky error: set by any multi-hot wordline, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wl_error <= 1'b0;
        end else if (!w_legal) begin
            r_wl_error <= 1'b1;
        end
    end

    assign WlError = r_wl_error;

    // Read port 1: zero for R0, bypass the in-flight write, else array.
    always_comb begin
        SrcData1 = w_regs[SrcReg1];
        if (SrcReg1 == R0_IDX) begin
            SrcData1 = '0;
        end else if (Wordline[SrcReg1] && w_legal) begin
            SrcData1 = DstData;
        end
    end

    // Read port 2: same selection rules, independent of port 1.
    always_comb begin
        SrcData2 = w_regs[SrcReg2];
        if (SrcReg2 == R0_IDX) begin
            SrcData2 = '0;
        end else if (Wordline[SrcReg2] && w_legal) begin
            SrcData2 = DstData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_16x16.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_16x16
//  Brief    : Scoreboard bench for reg_file_16x16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_16x16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Wordline;
    logic [15:0] DstData;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;
    logic        WlError;

    reg_file_16x16 #(
        .DATA_W   (16),
        .NUM_REGS (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Wordline (Wordline),
        .DstData  (DstData),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2),
        .WlError  (WlError)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;   // 1: SrcData1, 2: SrcData2, 3: WlError
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] mdl [16];
    logic        mdl_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic wl_legal(input logic [15:0] wl);
        return ($countones(wl) <= 1);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [3:0] idx);
        if (idx == 4'd0)                             return 16'h0000;
        if (Wordline[idx] && wl_legal(Wordline))     return DstData;
        return mdl[idx];
    endfunction

    task automatic push_exp(input string tag);
        sb_t e;
        e.tag = {tag, ".p1"}; e.port = 1; e.exp = exp_rd(SrcReg1);       sb_q.push_back(e);
        e.tag = {tag, ".p2"}; e.port = 2; e.exp = exp_rd(SrcReg2);       sb_q.push_back(e);
        e.tag = {tag, ".err"}; e.port = 3; e.exp = {15'b0, mdl_err};     sb_q.push_back(e);
    endtask

    task automatic observe();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.port)
                1:       chk(e.tag, SrcData1, e.exp);
                2:       chk(e.tag, SrcData2, e.exp);
                default: chk(e.tag, {15'b0, WlError}, e.exp);
            endcase
        end
    endtask

    task automatic model_edge();
        @(posedge clk);
        if (!rst) begin
            if (wl_legal(Wordline)) begin
                for (int k = 1; k < 16; k++) begin
                    if (Wordline[k]) mdl[k] = DstData;
                end
            end else begin
                mdl_err = 1'b1;
            end
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) mdl[k] = 16'h0000;
        mdl_err = 1'b0;
    endtask

    // One cycle: drive at the falling edge, check combinational outputs
    // shortly after, then advance the model on the rising edge.
    task automatic step(input logic [15:0] wl, input logic [15:0] d,
                        input logic [3:0] s1, input logic [3:0] s2, input string tag);
        @(negedge clk);
        Wordline = wl;
        DstData  = d;
        SrcReg1  = s1;
        SrcReg2  = s2;
        #1;
        push_exp(tag);
        observe();
        model_edge();
    endtask

    initial begin
        logic [15:0] wl_r;
        clear_model();
        rst      = 1'b1;
        Wordline = 16'h0000;
        DstData  = 16'h0000;
        SrcReg1  = 4'd5;
        SrcReg2  = 4'd0;
        #1;
        push_exp("reset_state");
        observe();

        // Bypass during reset; array must stay clear.
        step(16'h0080, 16'h1111, 4'd7, 4'd7, "rst_bypass");
        step(16'h0000, 16'h0000, 4'd7, 4'd7, "rst_no_write");
        @(negedge clk);
        rst = 1'b0;

        // Reset clear mid-cycle.
        step(16'h0020, 16'hBEEF, 4'd5, 4'd0, "r5_write");
        #2;
        Wordline = 16'h0000;
        SrcReg1  = 4'd5;
        SrcReg2  = 4'd5;
        #1;
        push_exp("pre_rst");
        observe();
        rst = 1'b1;
        #0.5;
        clear_model();
        push_exp("mid_rst");
        observe();
        chk("mid_rst.const", SrcData1, 16'h0000);
        #0.5;
        rst = 1'b0;

        // Basic write/read.
        step(16'h0008, 16'h1234, 4'd3, 4'd4, "basic_wr");
        step(16'h0000, 16'h0000, 4'd3, 4'd4, "basic_rd");
        chk("basic_rd.const", SrcData1, 16'h1234);

        // Bypass on both ports.
        step(16'h0080, 16'h00AA, 4'd7, 4'd7, "r7_init");
        step(16'h0080, 16'h5555, 4'd7, 4'd7, "bypass");
        chk("bypass.const", SrcData2, 16'h5555);
        step(16'h0000, 16'h0000, 4'd7, 4'd7, "bypass_after");

        // R0 hardwired, no error for R0-only wordline.
        step(16'h0001, 16'hFFFF, 4'd0, 4'd0, "r0_wr");
        step(16'h0000, 16'h0000, 4'd0, 4'd0, "r0_rd");

        // Illegal wordline.
        step(16'h0004, 16'h0002, 4'd2, 4'd9, "r2_init");
        step(16'h0200, 16'h0009, 4'd2, 4'd9, "r9_init");
        step(16'h0204, 16'hDEAD, 4'd9, 4'd2, "illegal");
        chk("illegal.const", SrcData1, 16'h0009);
        step(16'h0000, 16'h0000, 4'd2, 4'd9, "illegal_after");
        chk("illegal_after.err", {15'b0, WlError}, 16'h0001);
        step(16'h0004, 16'h0F0F, 4'd2, 4'd9, "legal_after_err");
        step(16'h0000, 16'h0000, 4'd2, 4'd9, "legal_after_rd");

        // Back-to-back writes.
        step(16'h8000, 16'h0001, 4'd14, 4'd15, "b2b_0");
        step(16'h4000, 16'h0002, 4'd14, 4'd15, "b2b_1");
        step(16'h8000, 16'h0003, 4'd14, 4'd15, "b2b_2");
        step(16'h0000, 16'h0000, 4'd14, 4'd15, "b2b_rd");
        chk("b2b_rd.r15", SrcData2, 16'h0003);

        // Random mix of legal, idle and occasional illegal wordlines.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       wl_r = 16'h0000;
                1:       wl_r = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: wl_r = 16'h0001 << $urandom_range(0, 15);
            endcase
            step(wl_r, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
        end
        for (int k = 0; k < 16; k += 2) begin
            step(16'h0000, 16'h0000, 4'(k), 4'(k + 1), "final_sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
